// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing block: default 800x600@72
// geometry, coordinate width and the payload carried down the sync pipeline.
package vga_pkg;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;

  typedef struct packed {
    logic hs;
    logic vs;
    logic iv;
  } sync_t;

  // True when v lies in [lo, lo+len-1].
  function automatic logic in_range(input logic [COORD_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift pipeline with a reset load value; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int            DEPTH = 1,
  parameter int            W     = 1,
  parameter logic [W-1:0]  INIT  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][W-1:0] stg;

    always_ff @(posedge clk) begin
      if (rst) begin
        stg <= {DEPTH{INIT}};
      end else if (ce) begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters, strobes, frame counter, and sync/colour
// outputs delayed to line up with a pixel source of PIX_LAT cycles latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int PIX_LAT  = 1,
  parameter int COLOR_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               in_view,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_cnt,
  input  logic [COLOR_W-1:0] pixel_in,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hsync,
  output logic               vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit the coordinate width");
  end
  if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_lat_chk
    $error("vga_timing_gen: PIX_LAT must be in 0..4");
  end

  // Inactive pipeline payload, loaded on reset so no stale sync leaks out.
  localparam sync_t IDLE = '{hs: ~H_POL, vs: ~V_POL, iv: 1'b0};

  logic x_wrap, y_wrap;

  assign x_wrap = (x == COORD_W'(H_TOTAL - 1));
  assign y_wrap = (y == COORD_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      if (x_wrap) begin
        x <= '0;
        if (y_wrap) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  logic  hs_act, vs_act;
  sync_t cur, dly;

  assign hs_act  = in_range(x, H_ACTIVE + H_FP, H_SYNC);
  assign vs_act  = in_range(y, V_ACTIVE + V_FP, V_SYNC);
  assign in_view = (x < COORD_W'(H_ACTIVE)) && (y < COORD_W'(V_ACTIVE));

  assign cur.hs = hs_act ? H_POL : ~H_POL;
  assign cur.vs = vs_act ? V_POL : ~V_POL;
  assign cur.iv = in_view;

  assign line_start  = pix_ce && (x == '0);
  assign frame_start = pix_ce && (x == '0) && (y == '0);

  vga_delay_line #(
    .DEPTH (PIX_LAT),
    .W     ($bits(sync_t)),
    .INIT  (IDLE)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .ce  (pix_ce),
    .d   (cur),
    .q   (dly)
  );

  assign hsync   = dly.hs;
  assign vsync   = dly.vs;
  assign rgb_out = dly.iv ? pixel_in : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: three instances (defaults, PIX_LAT=3,
// tiny geometry) checked every cycle against a queue-based reference.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       iv;
    logic [5:0] px;
  } ent_t;

  localparam ent_t IDLE_A = '{hs: 1'b0, vs: 1'b0, iv: 1'b0, px: 6'd0};
  localparam ent_t IDLE_B = '{hs: 1'b1, vs: 1'b1, iv: 1'b0, px: 6'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [10:0] x_a1, y_a1, x_a3, y_a3, x_b, y_b;
  logic        iv_a1, iv_a3, iv_b, ls_a1, ls_a3, ls_b, fs_a1, fs_a3, fs_b;
  logic        hs_a1, hs_a3, hs_b, vs_a1, vs_a3, vs_b;
  logic [15:0] fc_a1, fc_a3, fc_b;
  logic [5:0]  rgb_a1, rgb_a3, rgb_b;
  logic [5:0]  px_a1 = 6'h2A;
  logic [5:0]  px_b  = 6'h15;
  logic [5:0]  src0, src1, src2;

  vga_timing_gen dut_a1 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x_a1), .y(y_a1), .in_view(iv_a1),
    .line_start(ls_a1), .frame_start(fs_a1), .frame_cnt(fc_a1), .pixel_in(px_a1),
    .rgb_out(rgb_a1), .hsync(hs_a1), .vsync(vs_a1));

  vga_timing_gen #(.PIX_LAT(3)) dut_a3 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x_a3), .y(y_a3), .in_view(iv_a3),
    .line_start(ls_a3), .frame_start(fs_a3), .frame_cnt(fc_a3), .pixel_in(src2),
    .rgb_out(rgb_a3), .hsync(hs_a3), .vsync(vs_a3));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x_b), .y(y_b), .in_view(iv_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b), .pixel_in(px_b),
    .rgb_out(rgb_b), .hsync(hs_b), .vsync(vs_b));

  // Pixel source with 3 pix_ce of latency, returning the low bits of x.
  always @(posedge clk) begin
    if (pix_ce) begin
      src0 <= x_a3[5:0];
      src1 <= src0;
      src2 <= src1;
    end
  end

  int          mx, my, bx, by;
  logic [15:0] mfc, bfc;
  ent_t        qa1[$], qa3[$], qb[$];

  function automatic ent_t ent_a(input int px, input int py);
    ent_t e;
    e.hs = (px >= 856 && px < 976);
    e.vs = (py >= 637 && py < 643);
    e.iv = (px < 800 && py < 600);
    e.px = px[5:0];
    return e;
  endfunction

  function automatic ent_t ent_b(input int px, input int py);
    ent_t e;
    e.hs = !(px == 9 || px == 10);
    e.vs = !(py == 5);
    e.iv = (px < 8 && py < 4);
    e.px = 6'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic ce);
    if (r) begin
      mx = 0; my = 0; mfc = '0;
      bx = 0; by = 0; bfc = '0;
      qa1 = '{IDLE_A};
      qa3 = '{IDLE_A, IDLE_A, IDLE_A};
      qb  = '{IDLE_B};
      chk_en = 1;
    end else if (ce) begin
      qa1.push_back(ent_a(mx, my)); void'(qa1.pop_front());
      qa3.push_back(ent_a(mx, my)); void'(qa3.pop_front());
      qb.push_back(ent_b(bx, by));  void'(qb.pop_front());
      if (mx == 1039) begin
        mx = 0;
        if (my == 665) begin my = 0; mfc = mfc + 16'd1; end else my++;
      end else mx++;
      if (bx == 11) begin
        bx = 0;
        if (by == 6) begin by = 0; bfc = bfc + 16'd1; end else by++;
      end else bx++;
    end
  endtask

  task automatic check_all();
    chk("a1_x", x_a1, mx);            chk("a1_y", y_a1, my);
    chk("a1_iv", iv_a1, (mx < 800 && my < 600));
    chk("a1_ls", ls_a1, (pix_ce && mx == 0));
    chk("a1_fs", fs_a1, (pix_ce && mx == 0 && my == 0));
    chk("a1_fc", fc_a1, mfc);
    chk("a1_hs", hs_a1, qa1[0].hs);   chk("a1_vs", vs_a1, qa1[0].vs);
    chk("a1_rgb", rgb_a1, qa1[0].iv ? 6'h2A : 6'h00);
    chk("a3_x", x_a3, mx);            chk("a3_y", y_a3, my);
    chk("a3_ls", ls_a3, (pix_ce && mx == 0));
    chk("a3_hs", hs_a3, qa3[0].hs);   chk("a3_vs", vs_a3, qa3[0].vs);
    chk("a3_rgb", rgb_a3, qa3[0].iv ? qa3[0].px : 6'h00);
    chk("b_x", x_b, bx);              chk("b_y", y_b, by);
    chk("b_iv", iv_b, (bx < 8 && by < 4));
    chk("b_ls", ls_b, (pix_ce && bx == 0));
    chk("b_fs", fs_b, (pix_ce && bx == 0 && by == 0));
    chk("b_fc", fc_b, bfc);
    chk("b_hs", hs_b, qb[0].hs);      chk("b_vs", vs_b, qb[0].vs);
    chk("b_rgb", rgb_b, qb[0].iv ? 6'h15 : 6'h00);
  endtask

  // One clock: drive, check combinational/registered state, take the edge.
  task automatic cyc(input logic r, input logic ce);
    rst = r; pix_ce = ce;
    #1;
    if (chk_en) check_all();
    @(posedge clk);
    model_update(r, ce);
    #1;
  endtask

  int hs_n, hs_first, ls_n, ls_last, hb_n, vb_n, off_strobe;

  initial begin
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("rst_x", x_a1, 0);      chk("rst_hs_a1", hs_a1, 0);
    chk("rst_hs_b", hs_b, 1);   chk("rst_vs_b", vs_b, 1);
    chk("rst_rgb_a3", rgb_a3, 0);

    // One full default line plus the first small-geometry frame.
    hs_n = 0; hs_first = -1; ls_n = 0; ls_last = -1; hb_n = 0; vb_n = 0;
    for (int t = 0; t <= 1040; t++) begin
      rst = 1'b0; pix_ce = 1'b1; #1;
      if (hs_a1) begin hs_n++; if (hs_first < 0) hs_first = t; end
      if (ls_a1) begin ls_n++; ls_last = t; end
      if (t < 12 && !hs_b) hb_n++;
      if (t < 84 && !vs_b) vb_n++;
      if (t == 84) begin chk("b_fc_84", fc_b, 1); chk("b_x_84", x_b, 0); end
      if (t == 100) chk("a3_rgb_t100", rgb_a3, 33);
      if (t == 900) chk("a3_rgb_hblank", rgb_a3, 0);
      cyc(1'b0, 1'b1);
    end
    chk("a1_hs_len", hs_n, 120);   chk("a1_hs_first", hs_first, 857);
    chk("a1_ls_n", ls_n, 2);       chk("a1_ls_last", ls_last, 1040);
    chk("b_hs_low_n", hb_n, 2);    chk("b_vs_low_n", vb_n, 12);

    // Reset in the middle of both small-geometry sync pulses.
    cyc(1'b1, 1'b1);
    for (int t = 0; t < 154; t++) cyc(1'b0, 1'b1);
    rst = 1'b0; pix_ce = 1'b1; #1;
    chk("b_hs_pre", hs_b, 0);  chk("b_vs_pre", vs_b, 0);  chk("b_fc_pre", fc_b, 1);
    cyc(1'b1, 1'b1);
    chk("mid_rst_x", x_b, 0);   chk("mid_rst_y", y_b, 0);
    chk("mid_rst_hs", hs_b, 1); chk("mid_rst_vs", vs_b, 1);
    chk("mid_rst_rgb", rgb_b, 0); chk("mid_rst_fc", fc_b, 0);

    // pix_ce at half rate: a default line spans 2080 clocks.
    ls_n = 0; off_strobe = 0;
    for (int k = 0; k <= 2080; k++) begin
      rst = 1'b0; pix_ce = (k % 2 == 0); #1;
      if (ls_a1) ls_n++;
      if (!pix_ce && (ls_a1 || fs_a1 || ls_b || fs_b)) off_strobe++;
      if (k == 2080) chk("tog_x_wrap", x_a1, 0);
      cyc(1'b0, (k % 2 == 0));
    end
    chk("tog_ls_n", ls_n, 2);
    chk("tog_off_strobe", off_strobe, 0);

    // Frame counter wrap from 0xFFFF, coincident with frame_start.
    cyc(1'b1, 1'b1);
    force dut_b.frame_cnt = 16'hFFFF;
    bfc = 16'hFFFF;
    cyc(1'b0, 1'b1);
    release dut_b.frame_cnt;
    for (int t = 1; t <= 84; t++) begin
      rst = 1'b0; pix_ce = 1'b1; #1;
      if (t == 83) begin chk("wrap_fc_pre", fc_b, 16'hFFFF); chk("wrap_fs_pre", fs_b, 0); end
      if (t == 84) begin chk("wrap_fc", fc_b, 16'h0000); chk("wrap_fs", fs_b, 1); end
      cyc(1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FP, default 56; H_SYNC, default 120; H_BP, default 64: horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE, default 600; V_FP, default 37; V_SYNC, default 6; V_BP, default 23: vertical geometry in lines.
REQ-004 SHALL have parameters H_POL, default 1, and V_POL, default 1: sync polarity, where 1 means the sync pulse is driven high.
REQ-005 SHALL have parameter PIX_LAT, default 1, range 0..4: clk cycles from x/y valid to the pixel_in response.
REQ-006 SHALL have parameter COLOR_W, default 6, width of the colour bus.
REQ-007 SHALL have port clk, input, 1 bit: clock. Reset is rst, synchronous, active-high; clock is clk.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port pix_ce, input, 1 bit: pixel clock enable; timing advances only when it is high.
REQ-010 SHALL have ports x and y, outputs, 11 bits each: current counter position.
REQ-011 SHALL have port in_view, output, 1 bit: x<H_ACTIVE and y<V_ACTIVE (undelayed).
REQ-012 SHALL have ports line_start and frame_start, outputs, 1 bit each: one-pix_ce pulses.
REQ-013 SHALL have port frame_cnt, output, 16 bits: completed frame count.
REQ-014 SHALL have port pixel_in, input, COLOR_W bits: colour from the pixel source.
REQ-015 SHALL have ports rgb_out (output, COLOR_W bits), hsync (output, 1 bit) and vsync (output, 1 bit): aligned VGA outputs.

Function
REQ-016 x SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_*) and wrap to 0; it advances only on a cycle with pix_ce=1.
REQ-017 y SHALL increment when x wraps, count 0..V_TOTAL-1, and wrap to 0 when x and y both wrap on the same cycle.
REQ-018 The internal horizontal sync SHALL be active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; its output level is H_POL when active and !H_POL otherwise.
REQ-019 The internal vertical sync SHALL be active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] for the whole of each such line; level is V_POL when active and !V_POL otherwise.
REQ-020 line_start SHALL be high exactly while x==0 and pix_ce=1.
REQ-021 frame_start SHALL be high exactly while x==0, y==0 and pix_ce=1.
REQ-022 frame_cnt SHALL increment, with modulo-2^16 wrap, on the pix_ce cycle where x and y both wrap.
REQ-023 The sync and in_view values SHALL pass through a PIX_LAT-deep shift pipeline, advanced only when pix_ce=1; hsync and vsync are the pipeline outputs.
REQ-024 rgb_out SHALL equal pixel_in when the delayed in_view is 1, and all-zero otherwise.
REQ-025 With PIX_LAT=0, hsync, vsync and rgb_out SHALL be combinational from the counters and pixel_in.
REQ-026 When pix_ce=0, all registers SHALL hold their values, and line_start and frame_start SHALL be 0.

Reset
REQ-027 On rst, x, y and frame_cnt SHALL be 0.
REQ-028 On rst, every pipeline stage SHALL be loaded with the inactive value (sync=!POL, in_view=0), so hsync=!H_POL, vsync=!V_POL and rgb_out=0 in the cycle after rst.
REQ-029 rst SHALL override pix_ce; a reset asserted mid-frame SHALL restart the frame at (0,0) with no partial sync pulse emitted.

Structure
REQ-030 A package vga_pkg SHALL hold the default 800x600@72 geometry constants and the coordinate width (11).
REQ-031 One sub-module, vga_delay_line (parameters DEPTH and W, with ce), SHALL implement the pipeline of REQ-023.
REQ-032 The totals H_TOTAL and V_TOTAL SHALL be local constants, and the block SHALL raise a static error if either exceeds 2047.

Verification
REQ-033 Test: defaults, pix_ce=1, run 1040 cycles after rst -> hsync=1 for exactly 120 cycles starting x=856 (+PIX_LAT), line_start at cycles 0 and 1040.
REQ-034 Test: small geometry H=8/1/2/1, V=4/1/1/1, H_POL=0, V_POL=0 -> period 12x7; hsync low x=9..10; vsync low on line 5; frame_cnt=1 after 84 cycles.
REQ-035 Test: PIX_LAT=3, pixel_in driven = x[5:0] -> rgb_out equals x delayed 3 cycles inside active area, 0 at x=800..1039 and at y>=600.
REQ-036 Test: pix_ce toggled 1/0 alternately -> the line takes 2080 clk cycles; there are no strobes on pix_ce=0 cycles; outputs hold.
REQ-037 Test: rst asserted at x=860, y=637 (inside both syncs) -> the next cycle shows x=0, y=0, hsync and vsync inactive, rgb_out=0, frame_cnt=0.
REQ-038 Test: force frame_cnt near wrap (run 65536 small frames) -> 0xFFFF wraps to 0x0000 coincident with frame_start.
